tt_checker: RTL

TT_CHECKER -- requirements
Module: tt_checker

---
 rtl/tt_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tt_checker.sv
// tt_checker: captures the response of a 4-input function over all 16 input
// vectors, compares each sample against a latched expected truth table, and
// flags out-of-order vectors and excessive idle gaps between vectors.
module tt_checker #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] exp_tt,
   input  logic        vec_valid,
   input  logic [3:0]  vec,
   input  logic        y,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  mismatch_cnt,
   output logic [15:0] cap_tt,
   output logic [3:0]  first_fail_idx,
   output logic        first_fail_vld,
   output logic        seq_err,
   output logic        timeout
);

   // Gap counter must be able to hold TIMEOUT_CYC itself.
   localparam int unsigned GapW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

   state_e            state_q, state_d;
   logic [15:0]       exp_q, exp_d;
   logic [15:0]       cap_q, cap_d;
   logic [4:0]        mm_q, mm_d;
   logic [3:0]        ffi_q, ffi_d;
   logic              ffv_q, ffv_d;
   logic              seq_q, seq_d;
   logic              to_q, to_d;
   // Five bits so that acceptance of vector 15 never wraps back to 0.
   logic [4:0]        nxt_q, nxt_d;
   logic [GapW-1:0]   gap_q, gap_d;

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         exp_q   <= '0;
         cap_q   <= '0;
         mm_q    <= '0;
         ffi_q   <= '0;
         ffv_q   <= 1'b0;
         seq_q   <= 1'b0;
         to_q    <= 1'b0;
         nxt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         cap_q   <= cap_d;
         mm_q    <= mm_d;
         ffi_q   <= ffi_d;
         ffv_q   <= ffv_d;
         seq_q   <= seq_d;
         to_q    <= to_d;
         nxt_q   <= nxt_d;
         gap_q   <= gap_d;
      end
   end

   // Next-state and result update: start handling, vector capture, gap timeout.
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      cap_d   = cap_q;
      mm_d    = mm_q;
      ffi_d   = ffi_q;
      ffv_d   = ffv_q;
      seq_d   = seq_q;
      to_d    = to_q;
      nxt_d   = nxt_q;
      gap_d   = gap_q;

      case (state_q)
         StIdle, StDone: begin
            // A start wins over any vector presented in the same cycle.
            if (start) begin
               state_d = StCapture;
               exp_d   = exp_tt;
               cap_d   = '0;
               mm_d    = '0;
               ffi_d   = '0;
               ffv_d   = 1'b0;
               seq_d   = 1'b0;
               to_d    = 1'b0;
               nxt_d   = '0;
               gap_d   = '0;
            end
         end

         StCapture: begin
            if (vec_valid) begin
               gap_d = '0;
               if ({1'b0, vec} == nxt_q) begin
                  cap_d[nxt_q[3:0]] = y;
                  nxt_d = nxt_q + 5'd1;
                  if (y != exp_q[nxt_q[3:0]]) begin
                     if (mm_q != 5'd16) begin
                        mm_d = mm_q + 5'd1;
                     end
                     if (!ffv_q) begin
                        ffi_d = nxt_q[3:0];
                        ffv_d = 1'b1;
                     end
                  end
                  if (nxt_q == 5'd15) begin
                     state_d = StDone;
                  end
               end else begin
                  // Out-of-order sample is dropped; only the sticky flag records it.
                  seq_d = 1'b1;
               end
            end else begin
               gap_d = gap_q + 1'b1;
               if (gap_q == GapW'(TIMEOUT_CYC - 1)) begin
                  to_d    = 1'b1;
                  state_d = StDone;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state and result registers.
   always_comb begin
      busy           = (state_q == StCapture);
      done           = (state_q == StDone);
      pass           = done && (mm_q == 5'd0) && !seq_q && !to_q;
      mismatch_cnt   = mm_q;
      cap_tt         = cap_q;
      first_fail_idx = ffi_q;
      first_fail_vld = ffv_q;
      seq_err        = seq_q;
      timeout        = to_q;
   end

endmodule
